// File: rtl/bt_pkg.sv
// rtl/bt_pkg.sv - states, command entry type and command tables for bt_cmd_seq
package bt_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_BOOT,
        ST_CFG,
        ST_IDLE,
        ST_CMD,
        ST_ERR
    } state_t;

    typedef struct packed {
        logic [4:0] start;
        logic [3:0] len;
    } cmd_t;

    localparam int NUM_CFG     = 2;
    localparam int NUM_BTN_TBL = 8;

    // Module configuration issued once after the boot banner.
    function automatic cmd_t cfg_entry(input logic [2:0] idx);
        cmd_t e;
        e = '0;
        case (idx)
            3'd0:    e = '{start: 5'd0, len: 4'd6};
            3'd1:    e = '{start: 5'd6, len: 4'd10};
            default: e = '0;
        endcase
        return e;
    endfunction

    // Button 0 = next track, button 1 = previous track, 2..7 spare.
    function automatic cmd_t btn_entry(input logic [2:0] idx);
        cmd_t e;
        e = '0;
        case (idx)
            3'd0:    e = '{start: 5'd16, len: 4'd4};
            3'd1:    e = '{start: 5'd20, len: 4'd4};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - two-flop synchroniser and press (falling edge) detector for one button
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= btn_n;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall = s3 & ~s2;

endmodule

// File: rtl/bt_cmd_seq.sv
// rtl/bt_cmd_seq.sv - Bluetooth module power-up, configuration and push-button command sequencer
module bt_cmd_seq
    import bt_pkg::*;
#(
    parameter int NUM_BTN     = 2,
    parameter int PWRUP_BITS  = 17,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_n,
    input  logic               resp_rcvd,
    output logic               send,
    output logic [4:0]         cmd_start,
    output logic [3:0]         cmd_len,
    output logic               cmd_n,
    output logic               busy,
    output logic               err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [2:0]    CFG_LAST  = 3'(NUM_CFG - 1);

    state_t state, state_nx;
    logic [PWRUP_BITS-1:0] hold_cnt;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry;
    logic [2:0] cfg_idx, cfg_nx, sel;
    logic resend_q, send_q, err_q;
    logic send_new, send_rep, set_resend, resp_ok, timeout, armed;
    cmd_t cur, new_cmd;
    logic [NUM_BTN-1:0] pending, fall, clr;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_edge u_edge (
            .clk   (clk),
            .rst   (rst),
            .btn_n (btn_n[g]),
            .fall  (fall[g])
        );
    end

    // A response in the cycle right after a send cannot belong to that send.
    assign resp_ok = resp_rcvd & ~send_q;
    assign timeout = (timer == TO_LAST);
    assign armed   = (state != ST_PWRUP) && (state != ST_ERR);

    always_comb begin
        state_nx   = state;
        send_new   = 1'b0;
        send_rep   = 1'b0;
        set_resend = 1'b0;
        new_cmd    = '0;
        cfg_nx     = cfg_idx;
        clr        = '0;
        sel        = '0;
        case (state)
            ST_PWRUP: if (&hold_cnt) state_nx = ST_BOOT;
            ST_BOOT: begin
                if (resp_ok) begin
                    send_new = 1'b1;
                    new_cmd  = cfg_entry(3'd0);
                    cfg_nx   = 3'd0;
                    state_nx = ST_CFG;
                end
            end
            ST_CFG, ST_CMD: begin
                if (resp_ok) begin
                    if (state == ST_CMD || cfg_idx == CFG_LAST) begin
                        state_nx = ST_IDLE;
                    end else begin
                        send_new = 1'b1;
                        cfg_nx   = cfg_idx + 3'd1;
                        new_cmd  = cfg_entry(cfg_idx + 3'd1);
                    end
                end else if (resend_q) begin
                    send_rep = 1'b1;
                end else if (timeout) begin
                    if (retry == RETRY_MAX) state_nx = ST_ERR;
                    else                    set_resend = 1'b1;
                end
            end
            ST_IDLE: begin
                // Scan downward so the lowest pending index is the one kept.
                for (int i = NUM_BTN - 1; i >= 0; i--) begin
                    if (pending[i]) begin
                        sel    = 3'(i);
                        clr    = '0;
                        clr[i] = 1'b1;
                    end
                end
                if (|pending) begin
                    send_new = 1'b1;
                    new_cmd  = btn_entry(sel);
                    state_nx = ST_CMD;
                end
            end
            ST_ERR:  state_nx = ST_PWRUP;
            default: state_nx = ST_PWRUP;
        endcase
    end

    assign send  = send_new | send_rep;
    assign busy  = (state != ST_IDLE);
    assign cmd_n = (state == ST_PWRUP) || (state == ST_ERR);
    assign err   = err_q;

    always_comb begin
        cmd_start = '0;
        cmd_len   = '0;
        if (send_new) begin
            cmd_start = new_cmd.start;
            cmd_len   = new_cmd.len;
        end else if (state == ST_CFG || state == ST_CMD) begin
            cmd_start = cur.start;
            cmd_len   = cur.len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_PWRUP;
            hold_cnt <= '0;
            timer    <= '0;
            retry    <= '0;
            cfg_idx  <= '0;
            resend_q <= 1'b0;
            send_q   <= 1'b0;
            err_q    <= 1'b0;
            cur      <= '0;
            pending  <= '0;
        end else begin
            state    <= state_nx;
            send_q   <= send;
            resend_q <= set_resend;
            cfg_idx  <= cfg_nx;
            err_q    <= err_q | (state_nx == ST_ERR);
            if (state == ST_ERR)        hold_cnt <= '0;
            else if (state == ST_PWRUP) hold_cnt <= hold_cnt + 1'b1;
            if (send_new) cur <= new_cmd;
            if (send)                                      timer <= '0;
            else if (state == ST_CFG || state == ST_CMD)  timer <= timer + 1'b1;
            if (send_new)      retry <= '0;
            else if (send_rep) retry <= retry + 1'b1;
            if (state == ST_ERR) pending <= '0;
            else                 pending <= (pending & ~clr) | (fall & {NUM_BTN{armed}});
        end
    end

endmodule

// File: tb/tb_bt_cmd_seq.sv
// tb/tb_bt_cmd_seq.sv - directed self-checking bench for bt_cmd_seq
module tb_bt_cmd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_n;
    logic       resp_rcvd;
    logic       send;
    logic [4:0] cmd_start;
    logic [3:0] cmd_len;
    logic       cmd_n;
    logic       busy;
    logic       err;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    bt_cmd_seq #(
        .NUM_BTN     (2),
        .PWRUP_BITS  (4),
        .TIMEOUT_CYC (50),
        .MAX_RETRY   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_n     (btn_n),
        .resp_rcvd (resp_rcvd),
        .send      (send),
        .cmd_start (cmd_start),
        .cmd_len   (cmd_len),
        .cmd_n     (cmd_n),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_send(input int max, output int n);
        n = 0;
        while (send !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        if (send !== 1'b1) n = -1;
    endtask

    task automatic count_sends(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (send === 1'b1) cnt++;
        end
    endtask

    // Boot banner followed by the two config responses; starts in BOOT.
    task automatic do_boot(input string tag);
        resp_rcvd = 1'b1; #1;
        check({tag, "_boot_send"}, send, 1);
        check({tag, "_cfg0_start"}, cmd_start, 0);
        check({tag, "_cfg0_len"}, cmd_len, 6);
        tick(); resp_rcvd = 1'b0;
        check({tag, "_no_back2back"}, send, 0);
        check({tag, "_cfg0_hold_len"}, cmd_len, 6);
        ticks(3);
        resp_rcvd = 1'b1; #1;
        check({tag, "_cfg1_send"}, send, 1);
        check({tag, "_cfg1_start"}, cmd_start, 6);
        check({tag, "_cfg1_len"}, cmd_len, 10);
        tick(); resp_rcvd = 1'b0;
        ticks(3);
        resp_rcvd = 1'b1; #1;
        check({tag, "_cfg_last_nosend"}, send, 0);
        tick(); resp_rcvd = 1'b0;
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_start"}, cmd_start, 0);
    endtask

    initial begin
        int n, cnt, t, err_at, cmdn_after;
        int sends[$];

        rst = 1'b1;
        btn_n = 2'b11;
        resp_rcvd = 1'b0;
        ticks(3);
        check("rst_cmd_n", cmd_n, 1);
        check("rst_send", send, 0);
        check("rst_start", cmd_start, 0);
        check("rst_len", cmd_len, 0);
        check("rst_busy", busy, 1);
        check("rst_err", err, 0);

        rst = 1'b0;
        n = 0;
        while (cmd_n === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("pwrup_cycles", n, 16);
        resp_rcvd = 1'b1; #1;
        resp_rcvd = 1'b0;
        tick();
        resp_rcvd = 1'b0;
        // The probe above sits inside one BOOT cycle and is undone before the edge.
        do_boot("init");

        resp_rcvd = 1'b1; #1;
        check("idle_resp_ignored", send, 0);
        tick(); resp_rcvd = 1'b0;
        check("idle_resp_busy", busy, 0);

        btn_n = 2'b10;
        wait_send(10, n);
        check("btn0_latency", n, 3);
        check("btn0_start", cmd_start, 16);
        check("btn0_len", cmd_len, 4);
        btn_n = 2'b11;
        tick();
        check("cmd_busy", busy, 1);
        check("cmd_hold_start", cmd_start, 16);
        tick();
        resp_rcvd = 1'b1; #1;
        check("cmd_resp_nosend", send, 0);
        tick(); resp_rcvd = 1'b0;
        check("cmd_to_idle", busy, 0);

        btn_n = 2'b01;
        wait_send(10, n);
        check("btn1_latency", n, 3);
        check("btn1_start", cmd_start, 20);
        btn_n = 2'b11;
        ticks(2);
        btn_n = 2'b00;
        ticks(5);
        btn_n = 2'b11;
        ticks(4);
        resp_rcvd = 1'b1; #1;
        check("prio_resp_nosend", send, 0);
        tick(); resp_rcvd = 1'b0;
        check("prio_first_send", send, 1);
        check("prio_first_start", cmd_start, 16);
        ticks(2);
        resp_rcvd = 1'b1; #1;
        tick(); resp_rcvd = 1'b0;
        check("prio_second_send", send, 1);
        check("prio_second_start", cmd_start, 20);
        check("prio_second_len", cmd_len, 4);
        ticks(2);
        resp_rcvd = 1'b1; #1;
        tick(); resp_rcvd = 1'b0;
        count_sends(10, cnt);
        check("prio_no_extra_send", cnt, 0);
        check("prio_idle", busy, 0);

        btn_n = 2'b10;
        wait_send(10, n);
        check("tie_latency", n, 3);
        btn_n = 2'b11;
        count_sends(49, cnt);
        check("tie_no_early_resend", cnt, 0);
        tick();
        resp_rcvd = 1'b1; #1;
        check("tie_resp_wins", send, 0);
        tick(); resp_rcvd = 1'b0;
        check("tie_idle", busy, 0);
        count_sends(60, cnt);
        check("tie_no_late_resend", cnt, 0);

        btn_n = 2'b10;
        wait_send(10, n);
        check("to_latency", n, 3);
        t = cyc;
        btn_n = 2'b11;
        err_at = -1;
        cmdn_after = -1;
        for (int i = 1; i <= 160; i++) begin
            tick();
            if (send === 1'b1) sends.push_back(cyc - t);
            if (err === 1'b1 && err_at < 0) err_at = cyc - t;
            if (cyc - t == 154) cmdn_after = int'(cmd_n);
        end
        check("to_resend_count", sends.size(), 2);
        if (sends.size() >= 2) begin
            check("to_resend1_cycle", sends[0], 51);
            check("to_resend2_cycle", sends[1], 102);
        end
        check("to_err_cycle", err_at, 153);
        check("to_cmd_n_reinit", cmdn_after, 1);

        n = 0;
        while (cmd_n === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("reinit_boot_reached", cmd_n, 0);
        check("err_sticky", err, 1);
        do_boot("reinit");

        btn_n = 2'b01;
        wait_send(10, n);
        check("rst_cmd_latency", n, 3);
        btn_n = 2'b11;
        ticks(2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_send", send, 0);
        check("arst_cmd_n", cmd_n, 1);
        check("arst_busy", busy, 1);
        check("arst_start", cmd_start, 0);
        check("arst_len", cmd_len, 0);
        check("arst_err", err, 0);
        ticks(2);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            resp_rcvd = (i % 2 == 0);
            tick();
            if (send === 1'b1) cnt++;
        end
        resp_rcvd = 1'b0;
        check("arst_no_send_after", cnt, 0);
        check("arst_still_pwrup", cmd_n, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
